// File: rtl/pe_chain_ctrl.sv
// Sequencer for a linear chain of NUM_PE processing elements computing a sliding dot product.
// Loads the tap weights, streams pixels into the chain and captures the valid chain sums.
module pe_chain_ctrl #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned NUM_PE       = 3,
    parameter int unsigned LEN_WIDTH    = 10,
    parameter int unsigned SUM_WIDTH    = 18
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic                           reuse_w,
    input  logic [LEN_WIDTH-1:0]           frame_len,
    input  logic                           w_valid,
    input  logic [WEIGHT_WIDTH-1:0]        w_data,
    output logic                           w_ready,
    input  logic                           px_valid,
    input  logic [DATA_WIDTH-1:0]          px_data,
    output logic                           px_ready,
    output logic                           pe_en,
    output logic [DATA_WIDTH-1:0]          pe_input,
    output logic [NUM_PE*WEIGHT_WIDTH-1:0] pe_weight_bus,
    input  logic [SUM_WIDTH-1:0]           array_sum,
    output logic                           out_valid,
    output logic [SUM_WIDTH-1:0]           out_data,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int unsigned WidxWidth = $clog2(NUM_PE);
    localparam logic [WidxWidth-1:0] LastTap     = WidxWidth'(NUM_PE - 1);
    localparam logic [LEN_WIDTH-1:0] MinLen      = LEN_WIDTH'(NUM_PE);
    localparam logic [LEN_WIDTH-1:0] FirstTagged = LEN_WIDTH'(NUM_PE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StCompute,
        StDrain,
        StDone
    } state_e;

    state_e                          state_q, state_d;
    logic [LEN_WIDTH-1:0]            frame_len_q, frame_len_d;
    logic [LEN_WIDTH-1:0]            pcnt_q, pcnt_d;
    logic [WidxWidth-1:0]            widx_q, widx_d;
    logic                            drain_q, drain_d;
    logic [NUM_PE*WEIGHT_WIDTH-1:0]  taps_q, taps_d;
    logic                            tag_q, tag_d;
    logic                            out_valid_q;
    logic [SUM_WIDTH-1:0]            out_data_q;

    always_comb begin
        state_d     = state_q;
        frame_len_d = frame_len_q;
        pcnt_d      = pcnt_q;
        widx_d      = widx_q;
        drain_d     = drain_q;
        taps_d      = taps_q;
        w_ready     = 1'b0;
        px_ready    = 1'b0;
        pe_en       = 1'b0;
        err         = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    frame_len_d = frame_len;
                    if (frame_len < MinLen) begin
                        err     = 1'b1;
                        state_d = StDone;
                    end else if (reuse_w) begin
                        state_d = StCompute;
                    end else begin
                        state_d = StLoadW;
                    end
                end
            end
            StLoadW: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    for (int unsigned i = 0; i < NUM_PE; i++) begin
                        if (widx_q == WidxWidth'(i)) begin
                            taps_d[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] = w_data;
                        end
                    end
                    if (widx_q == LastTap) begin
                        widx_d  = '0;
                        state_d = StCompute;
                    end else begin
                        widx_d = widx_q + WidxWidth'(1);
                    end
                end
            end
            StCompute: begin
                px_ready = 1'b1;
                pe_en    = px_valid;
                if (px_valid) begin
                    pcnt_d = pcnt_q + LEN_WIDTH'(1);
                    if (pcnt_q == frame_len_q - LEN_WIDTH'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Two cycles let the last tag reach out_valid before done.
                drain_d = 1'b1;
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if ((state_d == StIdle) && (state_q != StIdle)) begin
            pcnt_d  = '0;
            widx_d  = '0;
            drain_d = 1'b0;
        end
    end

    // Only accepts from the (NUM_PE-1)th pixel on see a full window in the chain.
    assign tag_d = pe_en && (pcnt_q >= FirstTagged);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            frame_len_q <= '0;
            pcnt_q      <= '0;
            widx_q      <= '0;
            drain_q     <= 1'b0;
            taps_q      <= '0;
            tag_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            frame_len_q <= frame_len_d;
            pcnt_q      <= pcnt_d;
            widx_q      <= widx_d;
            drain_q     <= drain_d;
            taps_q      <= taps_d;
            tag_q       <= tag_d;
            out_valid_q <= tag_q;
            if (tag_q) begin
                out_data_q <= array_sum;
            end
        end
    end

    assign pe_input      = px_data;
    assign pe_weight_bus = taps_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_pe_chain_ctrl.sv
// Bench for pe_chain_ctrl: a behavioural PE chain drives array_sum, and a per-cycle checker
// compares results, done/err timing and the pe_en gating against a sliding dot-product model.
module tb_pe_chain_ctrl;

    localparam int DW = 8;
    localparam int WW = 8;
    localparam int NP = 3;
    localparam int LW = 10;
    localparam int SW = 18;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic              reuse_w = 1'b0;
    logic [LW-1:0]     frame_len = '0;
    logic              w_valid = 1'b0;
    logic [WW-1:0]     w_data = '0;
    logic              w_ready;
    logic              px_valid = 1'b0;
    logic [DW-1:0]     px_data = '0;
    logic              px_ready;
    logic              pe_en;
    logic [DW-1:0]     pe_input;
    logic [NP*WW-1:0]  pe_weight_bus;
    logic [SW-1:0]     array_sum;
    logic              out_valid;
    logic [SW-1:0]     out_data;
    logic              busy;
    logic              done;
    logic              err;

    pe_chain_ctrl #(
        .DATA_WIDTH  (DW),
        .WEIGHT_WIDTH(WW),
        .NUM_PE      (NP),
        .LEN_WIDTH   (LW),
        .SUM_WIDTH   (SW)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .reuse_w      (reuse_w),
        .frame_len    (frame_len),
        .w_valid      (w_valid),
        .w_data       (w_data),
        .w_ready      (w_ready),
        .px_valid     (px_valid),
        .px_data      (px_data),
        .px_ready     (px_ready),
        .pe_en        (pe_en),
        .pe_input     (pe_input),
        .pe_weight_bus(pe_weight_bus),
        .array_sum    (array_sum),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Behavioural PE chain: pixel shift register gated by pe_en, sum of products with the bus.
    logic [DW-1:0] pe_x [NP];
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NP; i++) pe_x[i] <= '0;
        end else if (pe_en) begin
            pe_x[0] <= pe_input;
            for (int i = 1; i < NP; i++) pe_x[i] <= pe_x[i-1];
        end
    end
    always_comb begin
        array_sum = '0;
        for (int i = 0; i < NP; i++) begin
            array_sum = array_sum + SW'(pe_x[i]) * SW'(pe_weight_bus[i*WW +: WW]);
        end
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Stimulus-owned frame description.
    int exp_w [NP];
    int pix [16];
    int cur_len = 0;
    int frame_seq = 0;
    int err_cyc = -10;

    // Checker-owned bookkeeping.
    int seen_seq = 0;
    int acc_idx = 0;
    int nres = 0;
    int obs [8];
    int done_due = -10;
    bit saw_w = 1'b0;
    bit saw_px = 1'b0;
    int exp_due [$];
    int exp_val [$];

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int model_sum(input int k);
        int s = 0;
        for (int j = 0; j < NP; j++) s += exp_w[j] * pix[k - j];
        return s;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rstn) begin
            exp_due.delete();
            exp_val.delete();
            done_due = -10;
        end else begin
            if (seen_seq != frame_seq) begin
                seen_seq = frame_seq;
                acc_idx  = 0;
                nres     = 0;
                done_due = -10;
                saw_w    = 1'b0;
                saw_px   = 1'b0;
            end
            if (w_ready) saw_w = 1'b1;
            if (px_ready) saw_px = 1'b1;
            chk(pe_en == (px_valid && px_ready), "pe_en_gating", pe_en, px_valid && px_ready);
            if (pe_en) chk(pe_input == px_data, "pe_input", pe_input, px_data);
            if (px_valid && px_ready) begin
                if (acc_idx >= NP - 1) begin
                    exp_due.push_back(cyc + 2);
                    exp_val.push_back(model_sum(acc_idx));
                end
                if (acc_idx == cur_len - 1) done_due = cyc + 3;
                acc_idx++;
            end
            if (exp_due.size() > 0 && exp_due[0] == cyc) begin
                chk(out_valid && (int'(out_data) == exp_val[0]), "result", out_data, exp_val[0]);
                if (nres < 8) obs[nres] = int'(out_data);
                nres++;
                void'(exp_due.pop_front());
                void'(exp_val.pop_front());
            end else begin
                chk(!out_valid, "spurious_out_valid", out_valid, 0);
            end
            if (done || cyc == done_due || cyc == err_cyc + 1) begin
                chk(done && (cyc == done_due || cyc == err_cyc + 1), "done_timing", done,
                    (cyc == done_due || cyc == err_cyc + 1));
            end
            if (err || cyc == err_cyc) chk(err && cyc == err_cyc, "err_timing", err, cyc == err_cyc);
        end
    end

    task automatic load_w();
        int i = 0;
        int g = 0;
        w_valid = 1'b1;
        w_data  = WW'(exp_w[0]);
        while (i < NP && g < 30) begin
            @(negedge clk);
            g++;
            if (w_ready) begin
                i++;
                @(posedge clk);
                #1;
                if (i < NP) w_data = WW'(exp_w[i]);
            end
        end
        w_valid = 1'b0;
        if (i < NP) chk(1'b0, "weight_accept_timeout", i, NP);
    endtask

    task automatic send_px(input int len, input bit gap, input int pulse_at);
        int g;
        for (int i = 0; i < len; i++) begin
            if (gap && i > 0) begin
                px_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            px_valid = 1'b1;
            px_data  = DW'(pix[i]);
            if (i == pulse_at) begin
                start     = 1'b1;
                frame_len = LW'(2);
            end
            g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (!px_ready && g < 20);
            if (!px_ready) begin
                chk(1'b0, "pixel_accept_timeout", i, len);
                px_valid = 1'b0;
                start    = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        px_valid = 1'b0;
    endtask

    task automatic begin_frame(input int len, input bit reuse);
        frame_seq++;
        cur_len = len;
        @(posedge clk);
        #1;
        start     = 1'b1;
        reuse_w   = reuse;
        frame_len = LW'(len);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input int len, input bit reuse, input bit gap, input int pulse_at,
                             input int exp_results);
        int g = 0;
        begin_frame(len, reuse);
        if (!reuse) load_w();
        send_px(len, gap, pulse_at);
        do begin
            @(negedge clk);
            g++;
        end while (busy && g < 40);
        chk(!busy, "return_to_idle", busy, 0);
        chk(nres == exp_results, "result_count", nres, exp_results);
        chk(exp_due.size() == 0, "results_outstanding", exp_due.size(), 0);
    endtask

    initial begin
        int bcnt;
        exp_w = '{1, 2, 3};
        for (int i = 0; i < 16; i++) pix[i] = i + 1;

        repeat (3) @(posedge clk);
        #1;
        chk(out_valid == 0, "reset_out_valid", out_valid, 0);
        chk(out_data == 0, "reset_out_data", out_data, 0);
        chk(done == 0 && err == 0 && busy == 0, "reset_flags", {done, err, busy}, 0);
        chk(pe_weight_bus == 0, "reset_weights", pe_weight_bus, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Frame 1: weights 1,2,3, pixels 1..5, no stalls.
        run_frame(5, 1'b0, 1'b0, -1, 3);
        chk(obs[0] == 10, "f1_r0_literal", obs[0], 10);
        chk(obs[1] == 16, "f1_r1_literal", obs[1], 16);
        chk(obs[2] == 22, "f1_r2_literal", obs[2], 22);
        chk(pe_weight_bus == 24'h030201, "f1_weight_bus", pe_weight_bus, 24'h030201);

        // Frame 2: same frame with a bubble between every pixel.
        run_frame(5, 1'b0, 1'b1, -1, 3);
        chk(obs[0] == 10 && obs[1] == 16 && obs[2] == 22, "f2_gap_values", obs[2], 22);

        // Too-short frame: err then done, no handshakes, one busy cycle.
        frame_seq++;
        @(posedge clk);
        #1;
        start     = 1'b1;
        reuse_w   = 1'b0;
        frame_len = LW'(2);
        err_cyc   = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        bcnt  = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        chk(bcnt == 1, "short_busy_cycles", bcnt, 1);
        chk(!saw_w && !saw_px, "short_no_ready", {saw_w, saw_px}, 0);

        // Reuse weights, 4 pixels.
        pix[0] = 4; pix[1] = 1; pix[2] = 7; pix[3] = 2;
        run_frame(4, 1'b1, 1'b0, -1, 2);
        chk(!saw_w, "reuse_no_w_ready", saw_w, 0);
        chk(pe_weight_bus == 24'h030201, "reuse_weight_bus", pe_weight_bus, 24'h030201);
        chk(obs[0] == 21 && obs[1] == 19, "reuse_values", obs[0] * 100 + obs[1], 2119);

        // start pulsed while computing must be ignored.
        for (int i = 0; i < 16; i++) pix[i] = i + 1;
        run_frame(5, 1'b1, 1'b0, 2, 3);
        chk(obs[0] == 10 && obs[1] == 16 && obs[2] == 22, "busy_start_values", obs[2], 22);

        // Reset mid-frame after two accepts.
        begin_frame(5, 1'b0);
        load_w();
        send_px(2, 1'b0, -1);
        rstn = 1'b0;
        #2;
        chk(out_valid == 0 && out_data == 0, "midreset_out", out_data, 0);
        chk(done == 0 && err == 0 && busy == 0, "midreset_flags", {done, err, busy}, 0);
        chk(pe_weight_bus == 0, "midreset_weights", pe_weight_bus, 0);
        chk(w_ready == 0 && px_ready == 0 && pe_en == 0, "midreset_hs", {w_ready, px_ready, pe_en}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        run_frame(5, 1'b0, 1'b0, -1, 3);
        chk(obs[0] == 10 && obs[1] == 16 && obs[2] == 22, "post_reset_values", obs[2], 22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_chain_ctrl.md
Name: pe_chain_ctrl

Overview:
- Sequencer for a linear chain of NUM_PE pe instances computing a NUM_PE-tap sliding dot product over a pixel frame.
- Holds the tap weights and drives every PE weight input in parallel.
- Streams pixels into the first PE with pe_en gating, and tags and captures the valid chain sums.
- Sits between the frame/weight sources and the PE chain; one frame per start.

Parameters:
- DATA_WIDTH, 8, pixel width
- WEIGHT_WIDTH, 8, weight width
- NUM_PE, 3, number of PEs/taps (>=2)
- LEN_WIDTH, 10, frame length counter width
- SUM_WIDTH, 18, chain sum width (>= DATA_WIDTH+WEIGHT_WIDTH+clog2(NUM_PE))

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  frame start pulse, sampled in IDLE only
- reuse_w  in  1  sampled with start; 1 = skip weight load, keep stored weights
- frame_len  in  LEN_WIDTH  pixels in frame, sampled with start
- w_valid  in  1  weight source valid
- w_data  in  WEIGHT_WIDTH  weight, tap order 0..NUM_PE-1
- w_ready  out  1  weight accept
- px_valid  in  1  pixel source valid
- px_data  in  DATA_WIDTH  pixel
- px_ready  out  1  pixel accept
- pe_en  out  1  enable to all PEs
- pe_input  out  DATA_WIDTH  pixel to first PE
- pe_weight_bus  out  NUM_PE*WEIGHT_WIDTH  tap i on bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
- array_sum  in  SUM_WIDTH  chain sum from the PE array
- out_valid  out  1  out_data valid (1-cycle pulse per result)
- out_data  out  SUM_WIDTH  captured chain sum
- busy  out  1  state != IDLE
- done  out  1  1-cycle end-of-frame pulse
- err  out  1  1-cycle pulse, frame_len < NUM_PE

Behaviour:
- Reset (async, rstn=0): state=IDLE; all counters 0; weight registers 0; every registered output 0. Outputs: out_valid=0, out_data=0, done=0, err=0.
- Reset mid-frame: abort to IDLE immediately; no done pulse; weights cleared.
- IDLE:
  - start=1 with frame_len<NUM_PE: pulse err, go to DONE.
  - start=1 with reuse_w=1: go to COMPUTE.
  - start=1 otherwise: go to LOAD_W.
  - frame_len is latched on start.
- LOAD_W:
  - w_ready=1.
  - Each w_valid&w_ready writes w_data to tap[widx], then widx increments.
  - After tap NUM_PE-1 is written, widx returns to 0 and the next state is COMPUTE.
  - w_ready=0 in all other states.
- COMPUTE:
  - px_ready=1.
  - pe_en = px_valid & px_ready (combinational); pe_input = px_data (combinational).
  - pe_en=0 on a stall, so the chain holds.
  - Each accept increments pcnt.
  - The accept with pcnt==frame_len-1 goes to DRAIN.
  - px_ready=0 and pe_en=0 outside COMPUTE.
- Result tagging:
  - tag_d <= pe_en & (pcnt >= NUM_PE-1), evaluated at the accept.
  - When tag_d=1: out_data <= array_sum and out_valid <= 1; otherwise out_valid <= 0.
  - Net latency: accept of pixel k (0-based, k>=NUM_PE-1) -> out_valid two cycles later.
  - Results per frame = frame_len-NUM_PE+1.
  - Output has no backpressure; out_data holds its last value between pulses.
- DRAIN: exactly 2 cycles to flush tag_d/out_valid, then DONE.
- DONE: done=1 for one cycle, then IDLE.
- Frame/state rules:
  - start while busy is ignored.
  - The weight bus is driven continuously from the tap registers and is stable through COMPUTE.
  - Stored weights persist across frames until reload or reset.
- Counters: pcnt and widx clear on entry to IDLE. pcnt compares against the latched frame_len. frame_len max = 2^LEN_WIDTH-1, with no wrap.

Test Plan:
- NUM_PE=3: start, frame_len=5; weights 1,2,3; pixels 1..5, no stalls.
  - Exactly 3 out_valid pulses.
  - out_data equals array_sum from the bench PE model, 2 cycles after accepts 3,4,5.
  - done 3 cycles after the last accept.
- Same frame with px_valid low every other cycle: pe_en is never high without px_valid, result count and values are unchanged, and out_valid spacing follows the accepts.
- start with frame_len=2: err and done pulse in consecutive cycles; w_ready and px_ready are never asserted; busy is high for 1 cycle.
- After frame 1, start with reuse_w=1 and frame_len=4: no w_ready; pe_weight_bus still holds {3,2,1}; 2 results.
- start pulsed during COMPUTE: ignored; pcnt and results are unaffected.
- rstn low after 2 pixel accepts: all outputs 0 and weights 0 asynchronously; no done pulse; a new start then works normally.
